// File: rtl/cpu_out_capture.sv
// cpu_out_capture: captures every word emitted on the CPU output port into a
// show-ahead FIFO and drains it over a valid/ready interface. It also keeps a
// saturating count of accepted words and raises a sticky done flag at TARGET.
//
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-low reset
//   outFlag   CPU output strobe, out valid this cycle
//   out       CPU output word
//   rd_ready  consumer accepts rd_data this cycle
//   rd_valid  FIFO non-empty, rd_data valid
//   rd_data   head-of-FIFO word (show-ahead)
//   count     words accepted since reset (saturating)
//   full      FIFO holds DEPTH words
//   empty     FIFO holds no words
//   overflow  sticky, a word was dropped
//   done      sticky, count reached TARGET
//   checksum  rotate-left-1/XOR signature of accepted words
//             (present only when OUTCAP_CHECKSUM_EN is defined)
//
// Optional feature macro: OUTCAP_CHECKSUM_EN

module cpu_out_capture #(
  parameter int unsigned WIDTH     = 36,
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned CNTWIDTH  = 16,
  parameter int unsigned TARGET    = 667
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                outFlag,
  input  logic [WIDTH-1:0]    out,
  input  logic                rd_ready,
  output logic                rd_valid,
  output logic [WIDTH-1:0]    rd_data,
  output logic [CNTWIDTH-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                done
`ifdef OUTCAP_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]    checksum
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam int unsigned PtrW  = ADDRWIDTH + 1;
  localparam logic [CNTWIDTH-1:0] TargetCnt = CNTWIDTH'(TARGET);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNTWIDTH-1:0] count_q;
  logic                overflow_q;
  logic                done_q;
  logic                push, pop;

  // Extra MSB on each pointer distinguishes full from empty when addresses match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[ADDRWIDTH-1:0] == rd_ptr_q[ADDRWIDTH-1:0]) &&
                    (wr_ptr_q[ADDRWIDTH] != rd_ptr_q[ADDRWIDTH]);
  assign rd_valid = !empty;
  assign rd_data  = mem[rd_ptr_q[ADDRWIDTH-1:0]];

  assign pop  = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = outFlag && (!full || pop);

  assign count    = count_q;
  assign overflow = overflow_q;
  assign done     = done_q;

  // Storage is deliberately not reset; pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q[ADDRWIDTH-1:0]] <= out;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (count_q != '1) begin
          count_q <= count_q + CNTWIDTH'(1);
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (outFlag && full && !pop) begin
        overflow_q <= 1'b1;
      end
      // Registered off count, so done lags the count reaching TARGET by one cycle.
      if (count_q >= TargetCnt) begin
        done_q <= 1'b1;
      end
    end
  end

`ifdef OUTCAP_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q;

  assign checksum = checksum_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= {checksum_q[WIDTH-2:0], checksum_q[WIDTH-1]} ^ out;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_out_capture.sv
// Self-checking bench for cpu_out_capture. A queue-based reference model tracks
// FIFO contents, count, overflow, done (and checksum when OUTCAP_CHECKSUM_EN is
// defined); directed scenarios and a randomized run compare the DUT to it.

module tb_cpu_out_capture;

  localparam int unsigned W      = 36;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TARGET = 5;
  localparam int unsigned CMAX   = 65535;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          outFlag = 1'b0;
  logic [W-1:0]  out = '0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [15:0]   count;
  logic          full, empty, overflow, done;
`ifdef OUTCAP_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  cpu_out_capture #(
    .WIDTH    (W),
    .ADDRWIDTH(4),
    .CNTWIDTH (16),
    .TARGET   (TARGET)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .outFlag (outFlag),
    .out     (out),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .done    (done)
`ifdef OUTCAP_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  int unsigned  m_count;
  bit           m_ovf, m_done;
  logic [W-1:0] m_ck;

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, then settle before the caller samples outputs.
  task automatic step(input logic rst, input logic flag, input logic [W-1:0] d,
                      input logic rdy);
    bit can_pop, was_full, do_push;
    @(negedge clock);
    reset = rst; outFlag = flag; out = d; rd_ready = rdy;
    @(posedge clock);
    if (!rst) begin
      mq.delete();
      m_count = 0; m_ovf = 0; m_done = 0; m_ck = '0;
    end else begin
      can_pop  = (mq.size() > 0) && rdy;
      was_full = (mq.size() == DEPTH);
      do_push  = flag && (!was_full || can_pop);
      if (flag && was_full && !can_pop) m_ovf = 1;
      if (m_count >= TARGET) m_done = 1;
      if (can_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(d);
        if (m_count < CMAX) m_count++;
        m_ck = {m_ck[W-2:0], m_ck[W-1]} ^ d;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty); end
    n_checks++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", full); end
    n_checks++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
    n_checks++;
    if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
    n_checks++;
    if (overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got ovf=%b done=%b want 0 0", overflow, done);
    end
  endtask

  task automatic test_single();
    do_reset();
    step(1'b1, 1'b1, 36'h0_0000_00A5, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 36'h0_0000_00A5) begin
      n_fail++; $display("FAIL single_data got v=%b d=%h want v=1 d=%h", rd_valid, rd_data,
                         36'h0_0000_00A5);
    end
    n_checks++;
    if (count !== 16'd1) begin n_fail++; $display("FAIL single_count got=%0d want=1", count); end
    step(1'b1, 1'b0, '0, 1'b1);
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, W'(i), 1'b0);
    n_checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full got full=%b ovf=%b want 1 0", full, overflow);
    end
    step(1'b1, 1'b1, W'(17), 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || count !== 16'd16) begin
      n_fail++; $display("FAIL ovf_drop got ovf=%b count=%0d want 1 16", overflow, count);
    end
    for (int i = 1; i <= 16; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(i)) begin
        n_fail++; $display("FAIL ovf_drain[%0d] got v=%b d=%0d want v=1 d=%0d", i, rd_valid,
                           rd_data, i);
      end
      step(1'b1, 1'b0, '0, 1'b1);
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_end_empty got=%b want=1", empty); end
  endtask

  task automatic test_full_pushpop();
    logic [W-1:0] exp_seq[$];
    do_reset();
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, W'(i), 1'b0);
    step(1'b1, 1'b1, W'(99), 1'b1);
    n_checks++;
    if (full !== 1'b1 || overflow !== 1'b0 || count !== 16'd17) begin
      n_fail++; $display("FAIL pp_full got full=%b ovf=%b count=%0d want 1 0 17", full, overflow,
                         count);
    end
    for (int i = 2; i <= 16; i++) exp_seq.push_back(W'(i));
    exp_seq.push_back(W'(99));
    foreach (exp_seq[k]) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_seq[k]) begin
        n_fail++; $display("FAIL pp_drain[%0d] got v=%b d=%0d want v=1 d=%0d", k, rd_valid,
                           rd_data, exp_seq[k]);
      end
      step(1'b1, 1'b0, '0, 1'b1);
    end
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_end_empty got=%b want=1", empty); end
  endtask

  task automatic test_done();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, W'(i + 100), 1'b1);
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL done_early[%0d] got=%b want=0", i, done); end
    end
    step(1'b1, 1'b0, '0, 1'b1);
    n_checks++;
    if (done !== 1'b1 || count !== 16'd5) begin
      n_fail++; $display("FAIL done_set got done=%b count=%0d want 1 5", done, count);
    end
    step(1'b1, 1'b1, W'(106), 1'b1);
    n_checks++;
    if (done !== 1'b1 || count !== 16'd6 || rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL done_more got done=%b count=%0d v=%b want 1 6 1", done, count,
                         rd_valid);
    end
    step(1'b0, 1'b1, W'(107), 1'b1);
    n_checks++;
    if (done !== 1'b0 || count !== 16'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL done_midreset got done=%b count=%0d empty=%b ovf=%b want 0 0 1 0",
                         done, count, empty, overflow);
    end
  endtask

  task automatic test_random();
    logic         rst, flag, rdy;
    logic [W-1:0] d;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 199) != 0);
      flag = ($urandom_range(0, 99) < 65);
      rdy  = ($urandom_range(0, 99) < 45);
      d    = {$urandom(), $urandom()} & {W{1'b1}};
      step(rst, flag, d, rdy);
      n_checks++;
      if (rd_valid !== (mq.size() > 0) || empty !== (mq.size() == 0) ||
          full !== (mq.size() == DEPTH)) begin
        n_fail++; $display("FAIL rand_status c=%0d got v=%b e=%b f=%b want occ=%0d", c, rd_valid,
                           empty, full, mq.size());
      end
      if (mq.size() > 0) begin
        n_checks++;
        if (rd_data !== mq[0]) begin
          n_fail++; $display("FAIL rand_data c=%0d got=%h want=%h", c, rd_data, mq[0]);
        end
      end
      n_checks++;
      if (count !== 16'(m_count) || overflow !== m_ovf || done !== m_done) begin
        n_fail++; $display("FAIL rand_regs c=%0d got cnt=%0d ovf=%b done=%b want %0d %b %b", c,
                           count, overflow, done, m_count, m_ovf, m_done);
      end
`ifdef OUTCAP_CHECKSUM_EN
      n_checks++;
      if (checksum !== m_ck) begin
        n_fail++; $display("FAIL rand_checksum c=%0d got=%h want=%h", c, checksum, m_ck);
      end
`endif
    end
  endtask

`ifdef OUTCAP_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    n_checks++;
    if (checksum !== '0) begin n_fail++; $display("FAIL ck_reset got=%h want=0", checksum); end
    step(1'b1, 1'b1, 36'h1, 1'b1);
    n_checks++;
    if (checksum !== 36'h1) begin n_fail++; $display("FAIL ck_first got=%h want=1", checksum); end
    step(1'b1, 1'b1, 36'h1, 1'b1);
    n_checks++;
    if (checksum !== 36'h3) begin n_fail++; $display("FAIL ck_second got=%h want=3", checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_pushpop();
    test_done();
`ifdef OUTCAP_CHECKSUM_EN
    test_checksum();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
